// File: rtl/scdc_i2c_responder_pkg.sv
// Shared definitions for the SCDC responder: register offsets, default target
// address and the FSM state encoding.
package scdc_pkg;

    localparam logic [6:0] SCDC_DEFAULT_ADDRESS = 7'h54;

    localparam logic [7:0] REG_SINK_VERSION     = 8'h01;
    localparam logic [7:0] REG_SOURCE_VERSION   = 8'h02;
    localparam logic [7:0] REG_TMDS_CONFIG      = 8'h20;
    localparam logic [7:0] REG_SCRAMBLER_STATUS = 8'h21;
    localparam logic [7:0] REG_STATUS_FLAGS0    = 8'h40;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_ADDRESS      = 4'd1,
        ST_ADDRESS_ACK  = 4'd2,
        ST_REGISTER     = 4'd3,
        ST_REGISTER_ACK = 4'd4,
        ST_WRITE_DATA   = 4'd5,
        ST_WRITE_ACK    = 4'd6,
        ST_READ_DATA    = 4'd7,
        ST_READ_ACK     = 4'd8
    } scdc_state_t;

endpackage

// File: rtl/scdc_i2c_responder_if.sv
// DDC pin bundle. Open-drain lines: an *_output of 0 pulls the wire low,
// 1 releases it; the board wired-ANDs all drivers onto *_input.
interface scdc_i2c_responder_if;
    logic scl_input;
    logic scl_output;
    logic sda_input;
    logic sda_output;

    modport master (output scl_input, output sda_input, input scl_output, input sda_output);
    modport slave  (input scl_input, input sda_input, output scl_output, output sda_output);
endinterface

// File: rtl/scdc_i2c_responder_line_filter.sv
// Two-flop synchronizer plus a run-length glitch filter for one I2C line;
// rise/fall pulses are aligned with the cycle the filtered level changes.
module i2c_line_filter #(
    parameter int FILTER_LENGTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic [3:0] r_count;
    logic       r_level;
    logic       r_rise;
    logic       r_fall;

    // A new level is accepted only after FILTER_LENGTH consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_count <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync[1] != r_level) begin
                if (r_count == 4'(FILTER_LENGTH - 1)) begin
                    r_level <= r_sync[1];
                    r_rise  <= r_sync[1];
                    r_fall  <= ~r_sync[1];
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 4'd1;
                end
            end else begin
                r_count <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/scdc_i2c_responder.sv
// HDMI sink SCDC target: I2C responder holding the source-writable TMDS
// configuration and source version, and reporting sink status on reads.
module scdc_i2c_responder
    import scdc_pkg::*;
#(
    parameter int         CLOCK_FREQUENCY = 0,
    parameter logic [6:0] ADDRESS         = SCDC_DEFAULT_ADDRESS,
    parameter logic [7:0] SINK_VERSION    = 8'h01,
    parameter int         FILTER_LENGTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    scdc_i2c_responder_if.slave    bus,
    input  logic                   hpd_clear,
    input  logic                   scrambling_detected,
    input  logic                   clock_detected,
    input  logic [2:0]             channel_locked,
    output logic                   scrambler_enable,
    output logic                   tmds_bit_clock_ratio,
    output logic [7:0]             source_version,
    output logic                   busy,
    output scdc_state_t            state_debug
);

    if (FILTER_LENGTH < 2 || FILTER_LENGTH > 15 || CLOCK_FREQUENCY < 0) begin : g_bad_params
        $error("scdc_i2c_responder: FILTER_LENGTH must be 2..15 and CLOCK_FREQUENCY >= 0");
    end

    logic w_scl_level, w_scl_rise, w_scl_fall;
    logic w_sda_level, w_sda_rise, w_sda_fall;

    i2c_line_filter #(.FILTER_LENGTH(FILTER_LENGTH)) u_scl_filter (
        .clock(clock), .reset(reset), .i_line(bus.scl_input),
        .o_level(w_scl_level), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LENGTH(FILTER_LENGTH)) u_sda_filter (
        .clock(clock), .reset(reset), .i_line(bus.sda_input),
        .o_level(w_sda_level), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    scdc_state_t r_state, w_next_state;
    logic [2:0]  r_bit_count;
    logic [1:0]  r_ack_phase;
    logic [7:0]  r_shift;
    logic [7:0]  r_pointer;
    logic        r_sda;
    logic [7:0]  r_source_version;
    logic [1:0]  r_tmds_config;

    logic       w_start, w_stop, w_last_bit, w_addr_match, w_write;
    logic [7:0] w_rx_byte, w_read_data;

    assign w_start      = w_sda_fall & w_scl_level;
    assign w_stop       = w_sda_rise & w_scl_level;
    assign w_last_bit   = (r_bit_count == 3'd7);
    assign w_rx_byte    = {r_shift[6:0], w_sda_level};
    assign w_addr_match = (w_rx_byte[7:1] == ADDRESS);
    assign w_write      = (r_state == ST_WRITE_DATA) && w_scl_rise && w_last_bit && !w_start && !w_stop;

    always_comb begin
        w_read_data = 8'h00;
        case (r_pointer)
            REG_SINK_VERSION:     w_read_data = SINK_VERSION;
            REG_SOURCE_VERSION:   w_read_data = r_source_version;
            REG_TMDS_CONFIG:      w_read_data = {6'b0, r_tmds_config};
            REG_SCRAMBLER_STATUS: w_read_data = {7'b0, scrambling_detected};
            REG_STATUS_FLAGS0:    w_read_data = {4'b0, channel_locked, clock_detected};
            default:              w_read_data = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = ST_ADDRESS;
        end else if (w_stop) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_ADDRESS:      if (w_scl_rise && w_last_bit) w_next_state = w_addr_match ? ST_ADDRESS_ACK : ST_IDLE;
                ST_ADDRESS_ACK:  if (w_scl_fall && r_ack_phase == 2'd1) w_next_state = r_shift[0] ? ST_READ_DATA : ST_REGISTER;
                ST_REGISTER:     if (w_scl_rise && w_last_bit) w_next_state = ST_REGISTER_ACK;
                ST_REGISTER_ACK: if (w_scl_fall && r_ack_phase == 2'd1) w_next_state = ST_WRITE_DATA;
                ST_WRITE_DATA:   if (w_scl_rise && w_last_bit) w_next_state = ST_WRITE_ACK;
                ST_WRITE_ACK:    if (w_scl_fall && r_ack_phase == 2'd1) w_next_state = ST_WRITE_DATA;
                ST_READ_DATA:    if (w_scl_rise && w_last_bit) w_next_state = ST_READ_ACK;
                ST_READ_ACK: begin
                    if (r_ack_phase == 2'd1 && w_scl_rise && w_sda_level) w_next_state = ST_IDLE;
                    else if (r_ack_phase == 2'd2 && w_scl_fall)           w_next_state = ST_READ_DATA;
                end
                default:         w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        busy                 = (r_state != ST_IDLE);
        state_debug          = r_state;
        bus.scl_output       = 1'b1;
        bus.sda_output       = r_sda;
        scrambler_enable     = r_tmds_config[0];
        tmds_bit_clock_ratio = r_tmds_config[1];
        source_version       = r_source_version;
    end

    // Ack phases: 0 = wait for the fall that starts the 9th clock, 1 = wait for
    // the fall that ends it; reads add 2 = controller ACKed, reload on next fall.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_count <= '0;
            r_ack_phase <= '0;
            r_shift     <= '0;
            r_pointer   <= '0;
            r_sda       <= 1'b1;
        end else if (w_start || w_stop) begin
            r_bit_count <= '0;
            r_ack_phase <= '0;
            r_sda       <= 1'b1;
        end else begin
            case (r_state)
                ST_ADDRESS, ST_REGISTER, ST_WRITE_DATA: begin
                    if (w_scl_rise) begin
                        r_shift     <= w_rx_byte;
                        r_bit_count <= r_bit_count + 3'd1;
                        if (r_state == ST_REGISTER && w_last_bit) r_pointer <= w_rx_byte;
                    end
                end
                ST_ADDRESS_ACK, ST_REGISTER_ACK, ST_WRITE_ACK: begin
                    if (w_scl_fall) begin
                        if (r_ack_phase == 2'd0) begin
                            r_sda       <= 1'b0;
                            r_ack_phase <= 2'd1;
                        end else begin
                            r_ack_phase <= 2'd0;
                            r_bit_count <= '0;
                            if (r_state == ST_ADDRESS_ACK && r_shift[0]) begin
                                r_shift <= {w_read_data[6:0], 1'b0};
                                r_sda   <= w_read_data[7];
                            end else begin
                                r_sda <= 1'b1;
                            end
                            if (r_state == ST_WRITE_ACK) r_pointer <= r_pointer + 8'd1;
                        end
                    end
                end
                ST_READ_DATA: begin
                    if (w_scl_rise) r_bit_count <= r_bit_count + 3'd1;
                    if (w_scl_fall) begin
                        r_sda   <= r_shift[7];
                        r_shift <= {r_shift[6:0], 1'b0};
                    end
                end
                ST_READ_ACK: begin
                    if (r_ack_phase == 2'd0 && w_scl_fall) begin
                        r_sda       <= 1'b1;
                        r_ack_phase <= 2'd1;
                    end else if (r_ack_phase == 2'd1 && w_scl_rise && !w_sda_level) begin
                        r_pointer   <= r_pointer + 8'd1;
                        r_ack_phase <= 2'd2;
                    end else if (r_ack_phase == 2'd2 && w_scl_fall) begin
                        r_shift     <= {w_read_data[6:0], 1'b0};
                        r_sda       <= w_read_data[7];
                        r_ack_phase <= 2'd0;
                        r_bit_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // hpd_clear wins over a write landing in the same cycle.
    always_ff @(posedge clock) begin
        if (reset || hpd_clear) begin
            r_source_version <= '0;
            r_tmds_config    <= '0;
        end else if (w_write) begin
            if (r_pointer == REG_SOURCE_VERSION) r_source_version <= w_rx_byte;
            if (r_pointer == REG_TMDS_CONFIG)    r_tmds_config    <= w_rx_byte[1:0];
        end
    end

endmodule

// File: tb/tb_scdc_i2c_responder.sv
// Bench for the SCDC responder: bit-banged I2C controller over a wired-AND SDA,
// expected ACK bits and read bytes queued per scenario and compared on arrival.
module tb_scdc_i2c_responder;
    import scdc_pkg::*;

    localparam int Q = 25;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hpd_clear = 1'b0;
    logic        scrambling_detected = 1'b0;
    logic        clock_detected = 1'b0;
    logic [2:0]  channel_locked = 3'b000;
    logic        scrambler_enable;
    logic        tmds_bit_clock_ratio;
    logic [7:0]  source_version;
    logic        busy;
    scdc_state_t state_debug;
    logic        tb_scl = 1'b1;
    logic        tb_sda = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    scdc_i2c_responder_if bus ();
    assign bus.scl_input = tb_scl;
    assign bus.sda_input = tb_sda & bus.sda_output;

    scdc_i2c_responder #(
        .CLOCK_FREQUENCY(100_000_000), .ADDRESS(7'h54), .SINK_VERSION(8'h01), .FILTER_LENGTH(4)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .hpd_clear(hpd_clear),
        .scrambling_detected(scrambling_detected), .clock_detected(clock_detected),
        .channel_locked(channel_locked), .scrambler_enable(scrambler_enable),
        .tmds_bit_clock_ratio(tmds_bit_clock_ratio), .source_version(source_version),
        .busy(busy), .state_debug(state_debug)
    );

    always #5 clock = ~clock;

    initial begin
        #900us;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b, output logic s);
        tb_sda = b;  wait_clk(Q);
        tb_scl = 1'b1; wait_clk(Q);
        s = bus.sda_input; wait_clk(Q);
        tb_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_start();
        tb_sda = 1'b1; wait_clk(Q);
        tb_scl = 1'b1; wait_clk(Q);
        tb_sda = 1'b0; wait_clk(Q);
        tb_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        tb_sda = 1'b0; wait_clk(Q);
        tb_scl = 1'b1; wait_clk(Q);
        tb_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s);
        send_bit(1'b1, s);
        obs_q.push_back({7'b0, s});
    endtask

    task automatic read_byte(input logic nack);
        logic s;
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(nack, s);
        obs_q.push_back(d);
    endtask

    task automatic test_reset();
        checks++; if (bus.sda_output !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", bus.sda_output); end
        checks++; if (bus.scl_output !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b expected 1", bus.scl_output); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({scrambler_enable, tmds_bit_clock_ratio, source_version} !== 10'h0) begin
            errors++; $display("FAIL reset_outputs: got %b/%b/%02h expected 0/0/00", scrambler_enable, tmds_bit_clock_ratio, source_version); end
        checks++; if (state_debug !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_debug, ST_IDLE); end
    endtask

    task automatic test_tmds_write();
        logic [7:0] e, o;
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA8);
        exp_q.push_back(8'h00); write_byte(8'h20);
        exp_q.push_back(8'h00); write_byte(8'h03);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmds_busy_high: got %b expected 1", busy); end
        checks++; if ({scrambler_enable, tmds_bit_clock_ratio} !== 2'b11) begin
            errors++; $display("FAIL tmds_outputs: got %b%b expected 11", tmds_bit_clock_ratio, scrambler_enable); end
        i2c_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmds_busy_low: got %b expected 0", busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL tmds_ack: got %02h expected %02h", o, e); end
        end
        obs_q.delete();
    endtask

    task automatic test_read_version();
        logic [7:0] e, o;
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA8);
        exp_q.push_back(8'h00); write_byte(8'h01);
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA9);
        exp_q.push_back(8'h01); read_byte(1'b1);
        checks++; if (bus.sda_output !== 1'b1 || state_debug !== ST_IDLE) begin
            errors++; $display("FAIL version_release: got sda=%b state=%0d expected sda=1 state=0", bus.sda_output, state_debug); end
        i2c_stop();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL version_read: got %02h expected %02h", o, e); end
        end
        obs_q.delete();
    endtask

    task automatic test_source_version();
        logic [7:0] e, o;
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA8);
        exp_q.push_back(8'h00); write_byte(8'h02);
        exp_q.push_back(8'h00); write_byte(8'h01);
        exp_q.push_back(8'h00); write_byte(8'hAA);
        i2c_stop();
        checks++; if (source_version !== 8'h01) begin errors++; $display("FAIL source_version: got %02h expected 01", source_version); end
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA8);
        exp_q.push_back(8'h00); write_byte(8'h03);
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA9);
        exp_q.push_back(8'h00); read_byte(1'b1);
        i2c_stop();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL source_sequence: got %02h expected %02h", o, e); end
        end
        obs_q.delete();
    endtask

    task automatic test_address_nack();
        logic [7:0] e, o;
        i2c_start();
        exp_q.push_back(8'h01); write_byte(8'hA0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy: got %b expected 0", busy); end
        exp_q.push_back(8'h01); write_byte(8'h02);
        i2c_stop();
        checks++; if (source_version !== 8'h01 || {tmds_bit_clock_ratio, scrambler_enable} !== 2'b11) begin
            errors++; $display("FAIL nack_regs: got %02h/%b%b expected 01/11", source_version, tmds_bit_clock_ratio, scrambler_enable); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL nack_ack: got %02h expected %02h", o, e); end
        end
        obs_q.delete();
    endtask

    task automatic test_status_burst();
        logic [7:0] e, o;
        scrambling_detected = 1'b1; clock_detected = 1'b1; channel_locked = 3'b111;
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA8);
        exp_q.push_back(8'h00); write_byte(8'h40);
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA9);
        exp_q.push_back(8'h0F); read_byte(1'b0);
        exp_q.push_back(8'h00); read_byte(1'b1);
        i2c_stop();
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA8);
        exp_q.push_back(8'h00); write_byte(8'h20);
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA9);
        exp_q.push_back(8'h03); read_byte(1'b0);
        exp_q.push_back(8'h01); read_byte(1'b1);
        i2c_stop();
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA8);
        exp_q.push_back(8'h00); write_byte(8'hFF);
        i2c_stop();
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA9);
        exp_q.push_back(8'h00); read_byte(1'b0);
        exp_q.push_back(8'h00); read_byte(1'b0);
        exp_q.push_back(8'h01); read_byte(1'b1);
        i2c_stop();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL status_burst: got %02h expected %02h", o, e); end
        end
        obs_q.delete();
    endtask

    task automatic test_hpd_clear();
        logic [7:0] e, o;
        hpd_clear = 1'b1;
        wait_clk(1);
        checks++; if ({scrambler_enable, tmds_bit_clock_ratio, source_version} !== 10'h0) begin
            errors++; $display("FAIL hpd_clear_now: got %b/%b/%02h expected 0/0/00", scrambler_enable, tmds_bit_clock_ratio, source_version); end
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA8);
        exp_q.push_back(8'h00); write_byte(8'h02);
        exp_q.push_back(8'h00); write_byte(8'h77);
        i2c_stop();
        hpd_clear = 1'b0;
        wait_clk(2);
        checks++; if (source_version !== 8'h00) begin errors++; $display("FAIL hpd_write_blocked: got %02h expected 00", source_version); end
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA8);
        exp_q.push_back(8'h00); write_byte(8'h02);
        exp_q.push_back(8'h00); write_byte(8'h77);
        i2c_stop();
        checks++; if (source_version !== 8'h77) begin errors++; $display("FAIL hpd_released_write: got %02h expected 77", source_version); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL hpd_ack: got %02h expected %02h", o, e); end
        end
        obs_q.delete();
    endtask

    task automatic test_glitch();
        logic [7:0] e, o;
        logic       s;
        logic [7:0] reg_offset;
        tb_sda = 1'b0; wait_clk(1); tb_sda = 1'b1;
        wait_clk(Q);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_start: got busy=%b expected 0", busy); end
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA8);
        reg_offset = 8'h02;
        tb_sda = 1'b0; wait_clk(Q);
        tb_scl = 1'b1; wait_clk(Q);
        tb_sda = 1'b1; wait_clk(1); tb_sda = 1'b0;
        wait_clk(Q);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_stop: got busy=%b expected 1", busy); end
        tb_scl = 1'b0; wait_clk(Q);
        for (int i = 6; i >= 0; i--) send_bit(reg_offset[i], s);
        send_bit(1'b1, s);
        obs_q.push_back({7'b0, s}); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); write_byte(8'h33);
        i2c_stop();
        checks++; if (source_version !== 8'h33) begin errors++; $display("FAIL glitch_write: got %02h expected 33", source_version); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL glitch_ack: got %02h expected %02h", o, e); end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_midtransfer();
        logic [7:0] e, o;
        logic       s;
        logic [7:0] addr;
        addr = 8'hA8;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(addr[i], s);
        checks++; if (bus.sda_output !== 1'b0) begin errors++; $display("FAIL midreset_ack_drive: got %b expected 0", bus.sda_output); end
        reset = 1'b1; wait_clk(1);
        checks++; if (bus.sda_output !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_release: got sda=%b busy=%b expected 1/0", bus.sda_output, busy); end
        reset = 1'b0;
        tb_sda = 1'b1; tb_scl = 1'b1; wait_clk(Q);
        checks++; if (source_version !== 8'h00) begin errors++; $display("FAIL midreset_regs: got %02h expected 00", source_version); end
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA8);
        exp_q.push_back(8'h00); write_byte(8'h02);
        exp_q.push_back(8'h00); write_byte(8'h12);
        i2c_stop();
        checks++; if (source_version !== 8'h12) begin errors++; $display("FAIL midreset_reacquire: got %02h expected 12", source_version); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL midreset_ack: got %02h expected %02h", o, e); end
        end
        obs_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(2);
        test_reset();
        test_tmds_write();
        test_read_version();
        test_source_version();
        test_address_nack();
        test_status_burst();
        test_hpd_clear();
        test_glitch();
        test_reset_midtransfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
